// File: rtl/fifo_burst_scheduler.sv
// fifo_burst_scheduler
// Grants one of NUM_CH sync FIFOs at a time and drains up to BURST_LEN
// entries from it. Urgent channels (non-empty with high threshold set) win
// over merely non-empty ones. Within the chosen class, arbitration is
// round-robin starting after the last completed grant.
//
// Ports
//   clk, rst_n     clock, async active-low reset
//   i_clr          synchronous clear; overrides every transition
//   i_en           allows new grants (a running burst is not aborted)
//   i_empty        per-channel FIFO empty flags
//   i_high         per-channel FIFO high-threshold flags
//   i_ready        downstream accepts one read this cycle
//   o_rd_en        per-channel read enable, one-hot or zero
//   o_sel          index of the granted channel
//   o_busy         state is not IDLE
//   o_burst_done   one-cycle pulse in GAP at the end of each grant
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for i_en and an eligible channel
// BURST | reading from channel o_sel while i_ready and not empty
// GAP   | one-cycle end of grant; o_burst_done, last_grant <= o_sel
module fifo_burst_scheduler #(
   parameter  int NUM_CH    = 4,
   parameter  int BURST_LEN = 4,
   localparam int SEL_W     = $clog2(NUM_CH),
   localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [NUM_CH-1:0] i_empty,
   input  logic [NUM_CH-1:0] i_high,
   input  logic              i_ready,
   output logic [NUM_CH-1:0] o_rd_en,
   output logic [SEL_W-1:0]  o_sel,
   output logic              o_busy,
   output logic              o_burst_done
);

   typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

   state_t            state, state_nx;
   logic [SEL_W-1:0]  sel_nx;
   logic [SEL_W-1:0]  last_grant, last_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [NUM_CH-1:0] eligible, urgent, mask;
   logic [SEL_W-1:0]  pick, idx_s;
   logic              found;
   logic              rd;
   logic              sel_empty;
   int                idx;

   assign eligible = ~i_empty;
   assign urgent   = eligible & i_high;
   // Urgent channels, when present, hide the non-urgent ones from arbitration.
   assign mask     = (|urgent) ? urgent : eligible;
   assign o_busy   = (state != IDLE);

   // Round-robin search: offsets 1..NUM_CH after last_grant, so the last
   // granted channel is considered last.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      idx_s = '0;
      for (int off = 1; off <= NUM_CH; off++) begin
         idx   = (int'(last_grant) + off) % NUM_CH;
         idx_s = SEL_W'(idx);
         if (!found && mask[idx_s]) begin
            found = 1'b1;
            pick  = idx_s;
         end
      end
   end

   always_comb begin
      state_nx     = state;
      sel_nx       = o_sel;
      cnt_nx       = cnt;
      last_nx      = last_grant;
      o_rd_en      = '0;
      o_burst_done = 1'b0;
      rd           = 1'b0;
      sel_empty    = i_empty[o_sel];
      if (i_clr) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         last_nx  = SEL_W'(NUM_CH - 1);
      end else begin
         case (state)
            IDLE: begin
               if (i_en && found) begin
                  sel_nx   = pick;
                  cnt_nx   = '0;
                  state_nx = BURST;
               end
            end
            BURST: begin
               rd             = i_ready & ~sel_empty;
               o_rd_en[o_sel] = rd;
               if (rd)
                  cnt_nx = cnt + CNT_W'(1);
               // Counter reaches BURST_LEN at most, then the grant ends.
               if (sel_empty || (rd && (cnt == CNT_W'(BURST_LEN - 1))))
                  state_nx = GAP;
            end
            GAP: begin
               o_burst_done = 1'b1;
               last_nx      = o_sel;
               state_nx     = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         o_sel      <= '0;
         cnt        <= '0;
         last_grant <= SEL_W'(NUM_CH - 1);
      end else begin
         state      <= state_nx;
         o_sel      <= sel_nx;
         cnt        <= cnt_nx;
         last_grant <= last_nx;
      end
   end

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// Bench for fifo_burst_scheduler (NUM_CH=4, BURST_LEN=4).
// The stimulus pushes the expected grant sequence (channel, read count,
// BURST-cycle span) into a queue; the monitor pops one entry per
// o_burst_done pulse and checks per-cycle legality of the outputs.
// The FIFOs are modelled by fill levels that drop on each read.
module tb_fifo_burst_scheduler;
   localparam int N  = 4;
   localparam int BL = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_clr = 1'b0;
   logic         i_en = 1'b0;
   logic         i_ready = 1'b0;
   logic [N-1:0] i_empty = '1;
   logic [N-1:0] i_high = '0;
   logic [N-1:0] o_rd_en;
   logic [1:0]   o_sel;
   logic         o_busy;
   logic         o_burst_done;

   always #5 clk = ~clk;

   fifo_burst_scheduler #(.NUM_CH(N), .BURST_LEN(BL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (i_clr),
      .i_en        (i_en),
      .i_empty     (i_empty),
      .i_high      (i_high),
      .i_ready     (i_ready),
      .o_rd_en     (o_rd_en),
      .o_sel       (o_sel),
      .o_busy      (o_busy),
      .o_burst_done(o_burst_done)
   );

   typedef struct {
      int ch;
      int reads;
      int span;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   passed = 0;
   int   lvl[N];

   task automatic check(input bit ok, input string name, input int act, input int req);
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: actual %0d required %0d", name, act, req);
   endtask

   task automatic push(input int ch, input int reads, input int span);
      exp_t x;
      x.ch = ch; x.reads = reads; x.span = span;
      exp_q.push_back(x);
   endtask

   task automatic upd_empty();
      for (int k = 0; k < N; k++) i_empty[k] = (lvl[k] == 0);
   endtask

   // One clock: sample reads mid-cycle, then apply them to the FIFO levels
   // just after the rising edge.
   task automatic tick(output bit done);
      logic [N-1:0] rd;
      @(negedge clk);
      rd   = o_rd_en;
      done = o_burst_done;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
         if (rd[k] && lvl[k] > 0) lvl[k]--;
      upd_empty();
   endtask

   task automatic run_grants(input int n, input int budget);
      int seen;
      bit d;
      seen = 0;
      i_en = 1'b1;
      for (int c = 0; c < budget && seen < n; c++) begin
         tick(d);
         if (d) seen++;
      end
      i_en = 1'b0;
      check(seen == n, "grant_timeout", seen, n);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      i_en    = 1'b0;
      i_clr   = 1'b0;
      i_ready = 1'b0;
      i_high  = '0;
      for (int k = 0; k < N; k++) lvl[k] = 0;
      upd_empty();
      repeat (2) @(negedge clk);
      check(o_rd_en == 0, "rst_rd_en", o_rd_en, 0);
      check(!o_busy, "rst_busy", o_busy, 0);
      check(!o_burst_done, "rst_done", o_burst_done, 0);
      check(o_sel == 0, "rst_sel", o_sel, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor
   int m_reads = 0;
   int m_span = 0;
   bit prev_done = 1'b0;
   bit prev_clr = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_reads = 0; m_span = 0; prev_done = 1'b0; prev_clr = 1'b0;
      end else begin
         if (prev_done) check(!o_busy, "idle_after_gap", o_busy, 0);
         if (prev_clr) check(!o_busy, "idle_after_clr", o_busy, 0);
         if (i_clr) begin
            check(o_rd_en == 0 && !o_burst_done, "clr_quiet", {o_burst_done, o_rd_en}, 0);
            m_reads = 0; m_span = 0;
         end else if (o_burst_done) begin
            check(o_rd_en == 0, "gap_rd_en", o_rd_en, 0);
            check(exp_q.size() != 0, "unexpected_grant", exp_q.size(), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check(o_sel == e.ch, "grant_ch", o_sel, e.ch);
               check(m_reads == e.reads, "burst_reads", m_reads, e.reads);
               check(m_span == e.span, "burst_span", m_span, e.span);
            end
            m_reads = 0; m_span = 0;
         end else if (o_busy) begin
            m_span++;
            if (o_rd_en != 0) begin
               m_reads++;
               check(o_rd_en == (4'b0001 << o_sel) && i_ready && ((o_rd_en & i_empty) == 0),
                     "read_legal", o_rd_en, 1 << o_sel);
            end
         end
         prev_done = o_burst_done;
         prev_clr  = i_clr;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit d;
      // Scenario 1: only channel 0 has data.
      do_reset();
      lvl[0] = 100; upd_empty();
      i_ready = 1'b1;
      push(0, 4, 4);
      run_grants(1, 30);

      // Scenario 2: all non-empty, no urgency -> 0,1,2,3,0.
      do_reset();
      for (int k = 0; k < N; k++) lvl[k] = 100;
      upd_empty();
      i_ready = 1'b1;
      push(0, 4, 4); push(1, 4, 4); push(2, 4, 4); push(3, 4, 4); push(0, 4, 4);
      run_grants(5, 60);

      // Scenario 3: last_grant=0, channel 3 urgent and holding 4 entries.
      for (int k = 0; k < N; k++) lvl[k] = 100;
      lvl[3] = 4;
      upd_empty();
      i_high = 4'b1000;
      push(3, 4, 4); push(0, 4, 4); push(1, 4, 4); push(2, 4, 4);
      run_grants(4, 60);
      i_high = '0;

      // Scenario 4: channel 2 holds 2 entries; empty seen one cycle later.
      do_reset();
      lvl[2] = 2; upd_empty();
      i_ready = 1'b1;
      push(2, 2, 3);
      run_grants(1, 30);

      // Scenario 5: ready toggles 1,0,... and i_en drops mid-burst.
      // 7 BURST cycles plus the GAP cycle.
      do_reset();
      lvl[0] = 100; upd_empty();
      push(0, 4, 7);
      i_ready = 1'b0;
      i_en = 1'b1;
      tick(d);
      i_en = 1'b0;
      d = 1'b0;
      for (int c = 0; c < 20 && !d; c++) begin
         i_ready = (c % 2 == 0);
         tick(d);
      end
      check(d, "s5_timeout", d, 1);

      // Scenario 6: clear on the 2nd read of channel 2's burst.
      do_reset();
      lvl[1] = 100; lvl[2] = 100; lvl[3] = 100; upd_empty();
      i_ready = 1'b1;
      push(1, 4, 4);
      run_grants(1, 30);
      i_en = 1'b1;
      tick(d);
      i_en = 1'b0;
      tick(d);
      i_clr = 1'b1;
      tick(d);
      i_clr = 1'b0;
      push(1, 4, 4);
      run_grants(1, 30);

      // Reset in the middle of a burst on channel 2.
      i_en = 1'b1;
      tick(d);
      i_en = 1'b0;
      tick(d);
      #2;
      check(o_rd_en == 4'b0100, "pre_rst_rd_en", o_rd_en, 4);
      rst_n = 1'b0;
      #1;
      check(o_rd_en == 0, "async_rst_rd_en", o_rd_en, 0);
      check(!o_busy, "async_rst_busy", o_busy, 0);
      do_reset();

      check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
